frame_sequencer: RTL and testbench

Per-frame scheduler for the game datapath. It divides the 50 MHz system clock to a 30 or 60 FPS frame tick and applies frame skipping to choose which ticks become update frames. On each update frame it runs an erase → update → draw handshake sequence against the VGA eraser, the game-logic step and the sprite drawer. It sits between the clock domain root and the draw/logic units, and replaces ad-hoc counter wiring in the top level.

---
 rtl/frame_pkg.sv | 8 +
 rtl/frame_period_counter.sv | 24 ++
 rtl/frame_sequencer.sv | 80 ++++++++
 tb/tb_frame_sequencer.sv | 189 ++++++++++++++++++
 4 files changed

// File: rtl/frame_pkg.sv
// frame_pkg: shared state encoding and frame-rate constants for the frame sequencer
package frame_pkg;
  typedef enum logic [1:0] {IDLE, ERASE, UPDATE, DRAW} state_t;
  localparam int DIV_30_DEF = 1666667;
  localparam int DIV_60_DEF = 833333;
  localparam logic FPS_30 = 1'b0;
  localparam logic FPS_60 = 1'b1;
endpackage

// File: rtl/frame_period_counter.sv
// frame_period_counter: divides the system clock to a 30/60 FPS frame tick
module frame_period_counter
  import frame_pkg::*;
#(
  parameter int DIV_30 = DIV_30_DEF,
  parameter int DIV_60 = DIV_60_DEF,
  parameter int CNT_W  = 21
) (
  input  logic clk,
  input  logic reset,
  input  logic enable,
  input  logic fps_sel,
  output logic frame_tick
);
  localparam logic [CNT_W-1:0] RELOAD_30 = CNT_W'(DIV_30 - 1);
  localparam logic [CNT_W-1:0] RELOAD_60 = CNT_W'(DIV_60 - 1);
  logic [CNT_W-1:0] cnt;
  // reset gating keeps the tick low while reset is asserted, before any clock edge
  assign frame_tick = enable && cnt == '0 && !reset;
  // count down while enabled; fps_sel only matters at the reload point
  always_ff @(posedge clk or posedge reset)
    if (reset) cnt <= '0;
    else if (enable) cnt <= cnt == '0 ? (fps_sel == FPS_60 ? RELOAD_60 : RELOAD_30) : cnt - 1'b1;
endmodule

// File: rtl/frame_sequencer.sv
// frame_sequencer: frame tick, frame skipping and erase/update/draw handshake sequencing
module frame_sequencer
  import frame_pkg::*;
#(
  parameter int DIV_30 = DIV_30_DEF,
  parameter int DIV_60 = DIV_60_DEF,
  parameter int CNT_W  = 21
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        enable,
  input  logic        fps_sel,
  input  logic [3:0]  skip_count,
  output logic        erase_req,
  input  logic        erase_done,
  output logic        update_req,
  input  logic        update_done,
  output logic        draw_req,
  input  logic        draw_done,
  output logic        frame_tick,
  output logic        busy,
  output logic        frame_overrun,
  output logic [15:0] update_count
);
  state_t     state;
  logic [3:0] skip;
  logic       upd_frame;

  frame_period_counter #(.DIV_30(DIV_30), .DIV_60(DIV_60), .CNT_W(CNT_W)) u_period (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .fps_sel(fps_sel),
    .frame_tick(frame_tick)
  );

  assign upd_frame = frame_tick && skip == '0;

  // skip counter: a tick finding it at zero is an update frame and reloads skip_count
  always_ff @(posedge clk or posedge reset)
    if (reset) skip <= '0;
    else if (frame_tick) skip <= skip == '0 ? skip_count : skip - 1'b1;

  // handshake FSM with registered request/busy outputs and sticky overrun flag
  always_ff @(posedge clk or posedge reset)
    if (reset) begin
      state         <= IDLE;
      erase_req     <= 1'b0;
      update_req    <= 1'b0;
      draw_req      <= 1'b0;
      busy          <= 1'b0;
      frame_overrun <= 1'b0;
      update_count  <= '0;
    end else begin
      if (upd_frame && state != IDLE) frame_overrun <= 1'b1;
      case (state)
        IDLE: if (upd_frame) begin
          state     <= ERASE;
          erase_req <= 1'b1;
          busy      <= 1'b1;
        end
        ERASE: if (erase_done) begin
          state      <= UPDATE;
          erase_req  <= 1'b0;
          update_req <= 1'b1;
        end
        UPDATE: if (update_done) begin
          state      <= DRAW;
          update_req <= 1'b0;
          draw_req   <= 1'b1;
        end
        DRAW: if (draw_done) begin
          state        <= IDLE;
          draw_req     <= 1'b0;
          busy         <= 1'b0;
          update_count <= update_count + 1'b1;
        end
      endcase
    end
endmodule

// File: tb/tb_frame_sequencer.sv
// tb_frame_sequencer: directed scoreboard bench for frame_sequencer with DIV_30=10, DIV_60=5
module tb_frame_sequencer;
  logic        clk = 1'b0;
  logic        reset, enable, fps_sel;
  logic [3:0]  skip_count;
  logic        erase_req, erase_done, update_req, update_done, draw_req, draw_done;
  logic        frame_tick, busy, frame_overrun;
  logic [15:0] update_count;
  int          checks = 0;
  int          errors = 0;
  int          cyc;
  int          tick_q[$];
  int          upd[$];

  frame_sequencer #(.DIV_30(10), .DIV_60(5), .CNT_W(21)) dut (
    .clk(clk),
    .reset(reset),
    .enable(enable),
    .fps_sel(fps_sel),
    .skip_count(skip_count),
    .erase_req(erase_req),
    .erase_done(erase_done),
    .update_req(update_req),
    .update_done(update_done),
    .draw_req(draw_req),
    .draw_done(draw_done),
    .frame_tick(frame_tick),
    .busy(busy),
    .frame_overrun(frame_overrun),
    .update_count(update_count)
  );

  always #5 clk = ~clk;

  initial begin
    #1000000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "watchdog");
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s @cyc %0d: observed %0h expected %0h", tag, cyc, obs, exp);
    end
  endtask

  task automatic observe();
    #1;
    if (frame_tick) begin
      if (tick_q.size() == 0) check("tick_extra", cyc, -1);
      else check("tick_cycle", cyc, tick_q.pop_front());
    end
  endtask

  task automatic step();
    @(posedge clk);
    @(negedge clk);
    cyc++;
  endtask

  task automatic end_ticks(input string tag);
    check({tag, "_ticks_left"}, tick_q.size(), 0);
    tick_q.delete();
  endtask

  // reference model for back-to-back handshakes with all dones returned immediately
  task automatic model_check();
    logic [2:0] exp_req = '0;
    int exp_cnt = 0;
    foreach (upd[i]) begin
      if (cyc - upd[i] == 1) exp_req[2] = 1'b1;
      if (cyc - upd[i] == 2) exp_req[1] = 1'b1;
      if (cyc - upd[i] == 3) exp_req[0] = 1'b1;
      if (cyc - upd[i] >= 4) exp_cnt++;
    end
    check("req", {erase_req, update_req, draw_req}, exp_req);
    check("busy", busy, exp_req != 0);
    check("update_count", update_count, exp_cnt);
    check("overrun", frame_overrun, 0);
  endtask

  task automatic run(input int n);
    repeat (n) begin
      observe();
      model_check();
      step();
    end
  endtask

  task automatic do_reset();
    reset = 1'b1; enable = 1'b0; fps_sel = 1'b0; skip_count = 4'd0;
    erase_done = 1'b1; update_done = 1'b1; draw_done = 1'b1;
    upd.delete(); tick_q.delete();
    repeat (2) @(negedge clk);
    reset = 1'b0; enable = 1'b1; cyc = 0;
  endtask

  initial begin
    cyc = 0;
    reset = 1'b1; enable = 1'b1; fps_sel = 1'b0; skip_count = 4'd0;
    erase_done = 1'b1; update_done = 1'b1; draw_done = 1'b1;
    #1;
    check("rst_tick", frame_tick, 0);
    check("rst_req", {erase_req, update_req, draw_req}, 0);
    check("rst_busy", busy, 0);
    check("rst_overrun", frame_overrun, 0);
    check("rst_count", update_count, 0);
    // basic 30 FPS, every tick an update frame
    do_reset();
    tick_q = '{0, 10, 20}; upd = '{0, 10, 20};
    run(25);
    end_ticks("t1");
    // frame skipping: update on every third tick
    do_reset();
    skip_count = 4'd2;
    tick_q = '{0, 10, 20, 30, 40, 50, 60}; upd = '{0, 30, 60};
    run(65);
    end_ticks("t2");
    // fps switch takes effect only at next reload
    do_reset();
    tick_q = '{0, 10, 15, 20}; upd = '{0, 10, 15, 20};
    run(4);
    fps_sel = 1'b1;
    run(21);
    end_ticks("t3");
    // stalled draw causes dropped frames and sticky overrun
    do_reset();
    draw_done = 1'b0;
    tick_q = '{0, 10, 20, 30, 40};
    for (int c = 0; c < 45; c++) begin
      draw_done = c >= 25 && c < 40;
      observe();
      if (c >= 3 && c <= 25) check("t4_draw_hold", draw_req, 1);
      check("t4_overrun", frame_overrun, c >= 11);
      if (c == 26) begin
        check("t4_idle_busy", busy, 0);
        check("t4_count1", update_count, 1);
      end
      if (c == 31) check("t4_new_erase", erase_req, 1);
      if (c == 34) check("t4_count2", update_count, 2);
      if (c == 44) check("t4_mid_draw", draw_req, 1);
      if (c < 44) step();
    end
    end_ticks("t4");
    // asynchronous reset mid-DRAW
    #2 reset = 1'b1;
    #1;
    check("t5_draw_req", draw_req, 0);
    check("t5_busy", busy, 0);
    check("t5_count", update_count, 0);
    check("t5_overrun", frame_overrun, 0);
    check("t5_tick", frame_tick, 0);
    enable = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    draw_done = 1'b1;
    @(negedge clk);
    #1 check("t5_no_tick_disabled", frame_tick, 0);
    @(negedge clk);
    enable = 1'b1; cyc = 0;
    tick_q = '{0};
    observe();
    end_ticks("t5");
    step();
    #1 check("t5_erase", erase_req, 1);
    // enable gap shifts the tick; in-flight handshake still completes
    do_reset();
    erase_done = 1'b0;
    tick_q = '{0, 17};
    for (int c = 0; c < 20; c++) begin
      enable = !(c >= 3 && c < 10);
      erase_done = c >= 6;
      observe();
      if (c == 5) check("t6_erase_wait", erase_req, 1);
      if (c == 7) check("t6_update", update_req, 1);
      if (c == 8) check("t6_draw", draw_req, 1);
      if (c == 9) begin
        check("t6_idle", busy, 0);
        check("t6_count", update_count, 1);
      end
      step();
    end
    end_ticks("t6");
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
